// File: rtl/dsm_pkg.sv
// Shared types and constants for the delta-sigma output stage: FSM state
// encoding, quantizer symbol codes and the gate pattern for each state.
package dsm_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_ZERO  = 3'd1,
        ST_POS   = 3'd2,
        ST_NEG   = 3'd3,
        ST_DEAD  = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b10;
    localparam logic [1:0] SYM_ILL  = 2'b11;

    // Gate vector ordering is {ha, la, hb, lb}.
    typedef struct packed {
        logic ha;
        logic la;
        logic hb;
        logic lb;
    } gates_t;

    localparam gates_t GATES_OFF  = gates_t'(4'b0000);
    localparam gates_t GATES_POS  = gates_t'(4'b1001);
    localparam gates_t GATES_NEG  = gates_t'(4'b0110);
    localparam gates_t GATES_ZERO = gates_t'(4'b0101);

    // Only the three drive states ever turn a switch on.
    function automatic gates_t gates_of(input state_t s);
        case (s)
            ST_POS:  return GATES_POS;
            ST_NEG:  return GATES_NEG;
            ST_ZERO: return GATES_ZERO;
            default: return GATES_OFF;
        endcase
    endfunction

    // The illegal symbol freewheels the bridge rather than driving it.
    function automatic state_t decode_sym(input logic [1:0] sym);
        case (sym)
            SYM_POS: return ST_POS;
            SYM_NEG: return ST_NEG;
            default: return ST_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/hbridge_deadtime_dt_counter.sv
// Loadable dead-time down-counter. done is high in the final dead cycle,
// i.e. while the count sits at 1; the count then runs out to 0 and idles.
module dt_counter #(
    parameter int CW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count;

    // Load wins over decrement; decrement stops at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == CW'(1));

endmodule

// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver for the 2-bit modulator symbol stream. Every change
// of drive passes through an all-off dead window of DEAD_CYC clocks; an
// overcurrent latches an all-off fault until explicitly cleared.
//
//   state | meaning
//   OFF   | bridge disabled or just out of fault, all gates off
//   ZERO  | freewheel, la=lb=1
//   POS   | +1 drive, ha=lb=1
//   NEG   | -1 drive, hb=la=1
//   DEAD  | all gates off while the dead-time counter runs
//   FAULT | latched overcurrent, all gates off
module hbridge_deadtime
    import dsm_pkg::*;
#(
    parameter int DEAD_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       pwm,
    input  logic             fault_i,
    input  logic             fault_clr,
    output logic             ha,
    output logic             la,
    output logic             hb,
    output logic             lb,
    output logic             busy,
    output logic             fault_o,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int CW = $clog2(DEAD_CYC + 1);

    state_t state;
    state_t state_nxt;
    state_t target;
    logic   dt_load;
    logic   dt_done;

    assign target = decode_sym(pwm);

    dt_counter #(.CW(CW)) u_dt_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (dt_load),
        .load_val (CW'(DEAD_CYC)),
        .done     (dt_done)
    );

    // Next-state decode: fault beats disable, disable beats symbol changes.
    // In DEAD the symbol is only looked at in the last cycle.
    always_comb begin
        state_nxt = state;
        dt_load   = 1'b0;
        if (fault_i) begin
            state_nxt = ST_FAULT;
        end else if (state == ST_FAULT) begin
            if (fault_clr) state_nxt = ST_OFF;
        end else if (!en) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = ST_DEAD;
                    dt_load   = 1'b1;
                end
                ST_ZERO, ST_POS, ST_NEG: begin
                    if (target != state) begin
                        state_nxt = ST_DEAD;
                        dt_load   = 1'b1;
                    end
                end
                ST_DEAD: begin
                    if (dt_done) state_nxt = target;
                end
                default: state_nxt = ST_OFF;
            endcase
        end
    end

    // State register with outputs decoded from the next state, so the gates
    // are registered yet always line up with the registered state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= ST_OFF;
            {ha, la, hb, lb} <= GATES_OFF;
            busy             <= 1'b0;
            fault_o          <= 1'b0;
        end else begin
            state            <= state_nxt;
            {ha, la, hb, lb} <= gates_of(state_nxt);
            busy             <= (state_nxt == ST_DEAD);
            fault_o          <= (state_nxt == ST_FAULT);
        end
    end

    // Saturating count of illegal symbols, independent of bridge state.
    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_cnt <= '0;
        end else if (pwm == SYM_ILL && illegal_cnt != '1) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Bench for hbridge_deadtime: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural
// model that tracks "current drive" and "dead cycles remaining" as integers.
module tb_hbridge_deadtime;

    localparam int DEAD_CYC = 4;
    localparam int CNT_W    = 8;

    localparam int D_NONE = 0;
    localparam int D_POS  = 1;
    localparam int D_NEG  = 2;
    localparam int D_ZERO = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [1:0]       pwm = 2'b00;
    logic             fault_i = 1'b0;
    logic             fault_clr = 1'b0;
    logic             ha, la, hb, lb, busy, fault_o;
    logic [CNT_W-1:0] illegal_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    int m_drive = D_NONE;
    int m_dead  = 0;
    bit m_flt   = 1'b0;
    int m_cnt   = 0;

    always #5 clock = ~clock;

    hbridge_deadtime #(.DEAD_CYC(DEAD_CYC), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .pwm         (pwm),
        .fault_i     (fault_i),
        .fault_clr   (fault_clr),
        .ha          (ha),
        .la          (la),
        .hb          (hb),
        .lb          (lb),
        .busy        (busy),
        .fault_o     (fault_o),
        .illegal_cnt (illegal_cnt)
    );

    function automatic int sym_drive(input logic [1:0] s);
        if (s == 2'b01) return D_POS;
        if (s == 2'b10) return D_NEG;
        return D_ZERO;
    endfunction

    function automatic logic [3:0] drive_gates(input int d);
        case (d)
            D_POS:   return 4'b1001;
            D_NEG:   return 4'b0110;
            D_ZERO:  return 4'b0101;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock of the reference behaviour, using the inputs seen at the edge.
    task automatic model_step();
        if (reset) begin
            m_drive = D_NONE;
            m_dead  = 0;
            m_flt   = 1'b0;
            m_cnt   = 0;
        end else begin
            if (pwm == 2'b11 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (fault_i) begin
                m_flt = 1'b1; m_drive = D_NONE; m_dead = 0;
            end else if (m_flt) begin
                if (fault_clr) m_flt = 1'b0;
            end else if (!en) begin
                m_drive = D_NONE; m_dead = 0;
            end else if (m_dead > 0) begin
                if (m_dead == 1) begin
                    m_dead  = 0;
                    m_drive = sym_drive(pwm);
                end else begin
                    m_dead--;
                end
            end else if (m_drive != sym_drive(pwm)) begin
                m_drive = D_NONE;
                m_dead  = DEAD_CYC;
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check("cycle", {ha, la, hb, lb, busy, fault_o, illegal_cnt},
              {drive_gates(m_drive), m_dead > 0, m_flt, m_cnt[CNT_W-1:0]});
        check("shoot_through", {31'd0, (ha & la) | (hb & lb)}, 32'd0);
    endtask

    // Expect exactly DEAD_CYC all-off busy cycles, then the given gate pattern.
    task automatic dead_then(input logic [3:0] exp, input string nm);
        for (int i = 0; i < DEAD_CYC; i++) begin
            tick();
            check({nm, "_dead"}, {busy, ha, la, hb, lb}, 5'b10000);
        end
        tick();
        check(nm, {busy, ha, la, hb, lb}, {1'b0, exp});
    endtask

    initial begin
        logic [1:0] syms [5];

        tick();
        tick();
        check("reset_state", {ha, la, hb, lb, busy, fault_o, illegal_cnt}, 32'd0);

        // Enable with +1 steady.
        reset = 1'b0; en = 1'b1; pwm = 2'b01;
        dead_then(4'b1001, "pos_first");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pos_hold", {busy, ha, la, hb, lb}, 5'b01001);
        end

        pwm = 2'b10;
        dead_then(4'b0110, "pos_to_neg");
        pwm = 2'b00;
        dead_then(4'b0101, "neg_to_zero");

        // Symbol changes inside DEAD are ignored; the last-cycle symbol wins.
        syms[0] = 2'b01; syms[1] = 2'b10; syms[2] = 2'b00; syms[3] = 2'b01; syms[4] = 2'b10;
        for (int i = 0; i < 5; i++) begin
            pwm = syms[i];
            tick();
            if (i < 4) check("toggle_dead", {busy, ha, la, hb, lb}, 5'b10000);
            else       check("toggle_end", {busy, ha, la, hb, lb}, 5'b00110);
        end

        // Illegal symbols: freewheel and saturate the counter.
        pwm = 2'b11;
        for (int i = 0; i < 300; i++) tick();
        check("ill_zero", {busy, ha, la, hb, lb}, 5'b00101);
        check("ill_sat", {24'd0, illegal_cnt}, 32'd255);

        // Fault path.
        pwm = 2'b01;
        dead_then(4'b1001, "pre_fault");
        fault_i = 1'b1;
        tick();
        check("fault_set", {ha, la, hb, lb, busy, fault_o}, 6'b000001);
        fault_clr = 1'b1;
        tick();
        check("clr_ignored", {31'd0, fault_o}, 32'd1);
        fault_i = 1'b0; fault_clr = 1'b0;
        tick();
        check("fault_held", {31'd0, fault_o}, 32'd1);
        fault_clr = 1'b1;
        tick();
        check("fault_clr", {ha, la, hb, lb, busy, fault_o}, 6'b000000);
        fault_clr = 1'b0;
        dead_then(4'b1001, "after_fault");

        // Reset mid-DEAD, then disable from NEG.
        pwm = 2'b10;
        dead_then(4'b0110, "to_neg");
        pwm = 2'b01;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("reset_mid_dead", {ha, la, hb, lb, busy, fault_o, illegal_cnt}, 32'd0);
        reset = 1'b0; pwm = 2'b10;
        dead_then(4'b0110, "neg_again");
        en = 1'b0;
        tick();
        check("disable", {ha, la, hb, lb, busy}, 5'b00000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 999) < 3);
            en        = ($urandom_range(0, 99) < 96);
            if ($urandom_range(0, 99) < 35) pwm = 2'($urandom_range(0, 3));
            fault_i   = ($urandom_range(0, 199) < 2);
            fault_clr = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
